als_spi_reader: RTL
===================

ALS_SPI_READER -- requirements
Module: als_spi_reader

Interface
REQ-001 SHALL have parameter CLKS_PER_HALF_BIT, default 4: i_Clock cycles per SCLK half-period; legal range >= 2.
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 100000: minimum i_Clock cycles from CS deassert to the next CS assert; legal range >= 2*CLKS_PER_HALF_BIT.
REQ-003 SHALL have port i_Clock, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port i_Rst_L, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port i_Enable, input, 1 bit: high permits new conversions.
REQ-006 SHALL have port i_SPI_MISO, input, 1 bit: serial data from the Pmod ALS ADC.
REQ-007 SHALL have port o_SPI_Clk, output, 1 bit: SPI clock; idles high.
REQ-008 SHALL have port o_SPI_CS_n, output, 1 bit: chip select, active-low.
REQ-009 SHALL have port o_Light, output, 8 bits: last light value; drives the BCD converter binary input.
REQ-010 SHALL have port o_DV, output, 1 bit: one-cycle pulse on o_Light update; drives the BCD converter start input.
REQ-011 SHALL have port o_Frame_Err, output, 1 bit: last frame had a nonzero leading bit.
REQ-012 SHALL have port o_Busy, output, 1 bit: high whenever o_SPI_CS_n is low.

Function
REQ-013 SHALL implement states IDLE, CS_SETUP, TRANSFER, CS_HOLD, DONE.
REQ-014 IDLE: gap counter increments from 0 each cycle, saturating at SAMPLE_PERIOD-1 ("ready"); when ready and i_Enable high, go to CS_SETUP and drive o_SPI_CS_n low on that edge.
REQ-015 IDLE with ready and i_Enable low: hold in IDLE; start on the first edge i_Enable is sampled high.
REQ-016 CS_SETUP: CS low, SCLK high, CLKS_PER_HALF_BIT cycles, then TRANSFER.
REQ-017 TRANSFER: exactly 16 SCLK periods; each period is CLKS_PER_HALF_BIT cycles low then CLKS_PER_HALF_BIT high.
REQ-018 i_SPI_MISO SHALL be sampled on the i_Clock edge that drives SCLK low-to-high, shifted MSB-first into a 16-bit frame register.
REQ-019 After the 16th high half-period, go to CS_HOLD: SCLK high, CS low, CLKS_PER_HALF_BIT cycles.
REQ-020 CS low duration SHALL be exactly 34*CLKS_PER_HALF_BIT cycles per conversion.
REQ-021 DONE (one cycle): o_SPI_CS_n high, o_Light <= frame[12:5], o_Frame_Err <= (frame[15:13] != 0), o_DV high; gap counter cleared to 0; next state IDLE.
REQ-022 o_DV SHALL be high for exactly one cycle per completed conversion and otherwise low.
REQ-023 o_Light and o_Frame_Err SHALL update only in DONE and hold stable between pulses.
REQ-024 o_Light SHALL be updated even when o_Frame_Err is set.
REQ-025 Trailing frame bits [4:0] SHALL be ignored.
REQ-026 i_Enable falling during CS_SETUP/TRANSFER/CS_HOLD SHALL NOT abort; the conversion completes with its o_DV; no new conversion follows.
REQ-027 SCLK low phase SHALL occur only while CS is low; no SCLK edges while CS high.
REQ-028 Counters SHALL be sized by $clog2 of their parameter; no wrap before terminal count.

Reset
REQ-029 On i_Rst_L low, asynchronously: state IDLE, gap counter 0, o_SPI_CS_n 1, o_SPI_Clk 1, o_Light 8'h00, o_DV 0, o_Frame_Err 0, o_Busy 0, frame register 0.
REQ-030 Reset mid-conversion SHALL abort with no o_DV; after release, the first CS assert SHALL be no earlier than SAMPLE_PERIOD-1 cycles after the first edge with i_Rst_L high.

Verification (CLKS_PER_HALF_BIT=2, SAMPLE_PERIOD=64)
REQ-031 Reset asserted mid-TRANSFER -> CS, SCLK high with no clock edge; o_Light=0x00, o_DV=0; no o_DV until after the next full conversion.
REQ-032 i_Enable=1, ADC model frame 16'h14A0 -> CS low 68 cycles, exactly 16 SCLK rising edges, o_Light=0xA5, o_Frame_Err=0, one o_DV pulse.
REQ-033 Frame 16'hE000 -> o_Light=0x00, o_Frame_Err=1, one o_DV.
REQ-034 Continuous i_Enable=1 -> next CS fall exactly 64 cycles after previous CS rise; o_Light holds between o_DV pulses.
REQ-035 i_Enable dropped at 5th SCLK rise -> conversion completes, one o_DV, CS stays high thereafter; re-raise -> CS falls on the next edge.
REQ-036 o_Light/o_DV into BCD converter, frame for 0xFF -> converter outputs 12'h255.

Source files
------------

// File: rtl/als_spi_reader.sv
// Periodic SPI reader for the Pmod ALS light sensor ADC.
// Shifts in a 16-bit frame and presents bits [12:5] as an 8-bit light level.
module als_spi_reader #(
    parameter int CLKS_PER_HALF_BIT = 4,
    parameter int SAMPLE_PERIOD     = 100000
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Enable,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_Clk,
    output logic       o_SPI_CS_n,
    output logic [7:0] o_Light,
    output logic       o_DV,
    output logic       o_Frame_Err,
    output logic       o_Busy
);

    localparam int CW = $clog2(CLKS_PER_HALF_BIT);
    localparam int GW = $clog2(SAMPLE_PERIOD);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(SAMPLE_PERIOD - 1);
    localparam logic [3:0]    BIT_LAST  = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        TRANSFER,
        CS_HOLD,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [CW-1:0] half_q, half_d;
    logic [3:0]    bit_q, bit_d;
    logic          high_q, high_d;
    logic [15:0]   frame_q, frame_d;
    logic          cs_n_q, cs_n_d;
    logic          sclk_q, sclk_d;
    logic [7:0]    light_q, light_d;
    logic          dv_q, dv_d;
    logic          err_q, err_d;

    logic half_end;

    assign half_end = (half_q == HALF_LAST);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        half_d  = half_q;
        bit_d   = bit_q;
        high_d  = high_q;
        frame_d = frame_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        light_d = light_q;
        err_d   = err_q;
        dv_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                sclk_d = 1'b1;
                cs_n_d = 1'b1;
                if (gap_q == GAP_LAST) begin
                    if (i_Enable) begin
                        state_d = CS_SETUP;
                        cs_n_d  = 1'b0;
                        half_d  = '0;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            CS_SETUP: begin
                if (half_end) begin
                    state_d = TRANSFER;
                    sclk_d  = 1'b0;
                    half_d  = '0;
                    bit_d   = '0;
                    high_d  = 1'b0;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end

            TRANSFER: begin
                if (!half_end) begin
                    half_d = half_q + 1'b1;
                end else begin
                    half_d = '0;
                    if (!high_q) begin
                        // MISO is captured on the same edge that raises SCLK
                        sclk_d  = 1'b1;
                        high_d  = 1'b1;
                        frame_d = {frame_q[14:0], i_SPI_MISO};
                    end else if (bit_q == BIT_LAST) begin
                        state_d = CS_HOLD;
                    end else begin
                        sclk_d = 1'b0;
                        high_d = 1'b0;
                        bit_d  = bit_q + 1'b1;
                    end
                end
            end

            CS_HOLD: begin
                if (half_end) begin
                    state_d = DONE;
                    cs_n_d  = 1'b1;
                    light_d = frame_q[12:5];
                    err_d   = |frame_q[15:13];
                    dv_d    = 1'b1;
                    gap_d   = '0;
                end else begin
                    half_d = half_q + 1'b1;
                end
            end

            DONE: begin
                // DONE counts as gap cycle 0 so CS rise to CS fall is one period
                state_d = IDLE;
                gap_d   = gap_q + 1'b1;
            end

            default: begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= IDLE;
            gap_q   <= '0;
            half_q  <= '0;
            bit_q   <= '0;
            high_q  <= 1'b0;
            frame_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            light_q <= 8'h00;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            half_q  <= half_d;
            bit_q   <= bit_d;
            high_q  <= high_d;
            frame_q <= frame_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            light_q <= light_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
        end
    end

    assign o_SPI_Clk   = sclk_q;
    assign o_SPI_CS_n  = cs_n_q;
    assign o_Light     = light_q;
    assign o_DV        = dv_q;
    assign o_Frame_Err = err_q;
    assign o_Busy      = ~cs_n_q;

endmodule
